katio_gate3_checker: RTL
========================

# katio_gate3_checker

Synthesizable response checker for the 3-input OR/NOR gate library cells. It is the receiving end of the exhaustive-sweep stimulus flow: a driver applies input vectors to the gate under test, and this block samples the applied vector with the observed OR/NOR outputs. It compares them against expected values, tracks which vectors have been seen, counts mismatches and reports pass/fail once all 2^WIDTH vectors are covered. It sits beside the gate under test in on-chip self-test and in regression benches.

## Interface
- WIDTH, 3: number of gate inputs; the vector space is 2^WIDTH.
- CNT_W, 8: error counter width.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins or restarts a sweep.
- vld  in  1  vec/or_obs/nor_obs are valid this cycle.
- vec  in  WIDTH  applied input vector ({a,b,c} for WIDTH=3, a = MSB).
- or_obs  in  1  observed OR output.
- nor_obs  in  1  observed NOR output.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  valid when done; 1 iff err_cnt == 0.
- err_cnt  out  CNT_W  mismatching samples, saturating.
- first_fail_vld  out  1  a failing sample has been captured.
- first_fail_vec  out  WIDTH  vec of the first failing sample.
- coverage  out  2^WIDTH  bit i set once vec == i has been sampled.
- signature  out  8  MISR signature (only with KATIO_CHK_MISR_EN).

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE.
- IDLE --start--> RUN. DONE --start--> RUN. RUN --start--> RUN (restart).
- Every start clears err_cnt, coverage, first_fail_vld, first_fail_vec and the MISR seed.
- RUN, vld=1: exp_or = |vec, exp_nor = ~exp_or. The sample fails if or_obs != exp_or or nor_obs != exp_nor. One failing sample adds exactly 1 to err_cnt, even when both outputs are wrong.
- Failing sample with first_fail_vld=0: capture vec and set first_fail_vld. Later failures do not overwrite it.
- err_cnt saturates at 2^CNT_W-1.
- coverage[vec] is set on every vld in RUN. Repeated vectors are counted and checked again but add no coverage.
- RUN -> DONE on the edge that samples the vld completing coverage (all bits 1).
- vld in IDLE or DONE is ignored: no counter, coverage or MISR change.
- start and vld in the same cycle: start wins and that sample is discarded.
- Reset values: busy=0, done=0, pass=0, err_cnt=0, first_fail_vld=0, first_fail_vec=0, coverage=0, signature=0xFF.

## Timing
- All outputs are registered.
- A sample presented with vld at edge k updates err_cnt, coverage and first_fail_* at edge k.
- The completing sample sets done=1 and busy=0 at edge k, with pass valid in the same cycle.
- done holds until the next start or reset.
- start at edge k gives busy=1 and cleared outputs from edge k.
- rst_n low at any time, including mid-sweep, forces reset values immediately. No partial sweep survives.
- Back-to-back vld every cycle is supported with no stall.

## Configuration
- KATIO_CHK_MISR_EN defined: an 8-bit MISR is compiled in.
  - Polynomial x^8+x^4+x^3+x^2+1, seed 0xFF on reset and start.
  - Each vld in RUN shifts in {vec, or_obs, nor_obs}, zero-padded to 8 bits on the LSB side.
  - signature port present; it freezes in DONE.
- Not defined: no MISR logic and no signature port. All other behaviour is identical.

## Structure
- Package katio_chk_pkg holds:
  - the state enum (IDLE, RUN, DONE)
  - MISR polynomial and seed constants
  - an expected-output function (WIDTH-generic OR reduction)
- Sub-module katio_misr8 (clk, rst_n, clr, en, din[7:0], sig[7:0]) holds the MISR. It is instantiated only under KATIO_CHK_MISR_EN.

## Test plan
- Correct sweep: start, then vec 000..111 with correct or/nor on consecutive cycles -> done=1 the cycle after the 8th vld, pass=1, err_cnt=0, coverage=0xFF, first_fail_vld=0.
- Stuck-at: or_obs forced 0 for vec=101, all else correct -> err_cnt=1, first_fail_vec=101, pass=0. A second fault at 110 gives err_cnt=2 with first_fail_vec still 101.
- Repeats and idle gaps: vec 000 sent 5 times, then 001..111 with vld gaps -> done only after 111, err_cnt=0. vld before start leaves coverage=0.
- Reset mid-sweep: rst_n low after 4 samples -> all outputs at reset values the same cycle. A fresh sweep then passes.
- Restart plus collision: start together with vld during RUN -> that sample is dropped and coverage=0. With CNT_W=2 and 6 failing samples -> err_cnt=3.
- MISR (macro on): a correct sweep 000..111 gives a signature matching the bench reference model. Flipping one nor_obs changes the signature.

Source files
------------

// File: rtl/katio_chk_pkg.sv
// Shared types and constants for the 3-input OR/NOR gate response checker.
// MISR constants are only consumed when KATIO_CHK_MISR_EN is defined.
package katio_chk_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } chk_state_e;

  // x^8 + x^4 + x^3 + x^2 + 1, top term implied by the shift-out bit
  localparam logic [7:0] MisrPoly = 8'h1D;
  localparam logic [7:0] MisrSeed = 8'hFF;

  // Expected OR output for an applied vector; callers zero-extend to 32 bits.
  function automatic logic exp_or(input logic [31:0] vec);
    return |vec;
  endfunction

endpackage

// File: rtl/katio_gate3_checker_if.sv
// Sample and result bundle between a sweep driver (master) and the checker (slave).
// The signature signal exists only when KATIO_CHK_MISR_EN is defined.
interface katio_gate3_checker_if #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned CNT_W = 8
);
  logic                  start;
  logic                  vld;
  logic [WIDTH-1:0]      vec;
  logic                  or_obs;
  logic                  nor_obs;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [CNT_W-1:0]      err_cnt;
  logic                  first_fail_vld;
  logic [WIDTH-1:0]      first_fail_vec;
  logic [2**WIDTH-1:0]   coverage;
`ifdef KATIO_CHK_MISR_EN
  logic [7:0]            signature;
`endif

  modport master (
    output start, vld, vec, or_obs, nor_obs,
    input  busy, done, pass, err_cnt, first_fail_vld, first_fail_vec, coverage
`ifdef KATIO_CHK_MISR_EN
    , input signature
`endif
  );

  modport slave (
    input  start, vld, vec, or_obs, nor_obs,
    output busy, done, pass, err_cnt, first_fail_vld, first_fail_vec, coverage
`ifdef KATIO_CHK_MISR_EN
    , output signature
`endif
  );

endinterface

// File: rtl/katio_misr8.sv
// 8-bit Galois MISR compacting checker samples; seeded on reset and on clr.
// Instantiated only when KATIO_CHK_MISR_EN is defined.
module katio_misr8
  import katio_chk_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] sig
);

  logic [7:0] sig_q, sig_d;

  always_comb begin
    sig_d = {sig_q[6:0], 1'b0} ^ (sig_q[7] ? MisrPoly : 8'h00) ^ din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= MisrSeed;
    end else if (clr) begin
      sig_q <= MisrSeed;
    end else if (en) begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/katio_gate3_checker.sv
// Response checker for 3-input OR/NOR cells: scores sampled vectors, tracks coverage
// and reports pass/fail after a full sweep. Define KATIO_CHK_MISR_EN to add a MISR signature.
module katio_gate3_checker
  import katio_chk_pkg::*;
#(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  katio_gate3_checker_if.slave bus
);

  localparam int unsigned     NumVec = 2 ** WIDTH;
  localparam logic [CNT_W-1:0] CntMax = '1;

  chk_state_e          state_q;
  logic                busy_q, done_q, pass_q;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic [NumVec-1:0]   coverage_q, coverage_d;
  logic                first_fail_vld_q;
  logic [WIDTH-1:0]    first_fail_vec_q;
  logic                sample, fail, want_or;

  // start takes priority, so a colliding sample is never scored
  always_comb begin
    sample     = (state_q == StRun) && bus.vld && !bus.start;
    want_or    = exp_or(32'(bus.vec));
    fail       = sample && ((bus.or_obs != want_or) || (bus.nor_obs != !want_or));
    coverage_d = coverage_q;
    if (sample) begin
      coverage_d[bus.vec] = 1'b1;
    end
    err_cnt_d = err_cnt_q;
    if (fail && (err_cnt_q != CntMax)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      err_cnt_q        <= '0;
      coverage_q       <= '0;
      first_fail_vld_q <= 1'b0;
      first_fail_vec_q <= '0;
    end else if (bus.start) begin
      state_q          <= StRun;
      busy_q           <= 1'b1;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      err_cnt_q        <= '0;
      coverage_q       <= '0;
      first_fail_vld_q <= 1'b0;
      first_fail_vec_q <= '0;
    end else begin
      case (state_q)
        StRun: begin
          if (sample) begin
            coverage_q <= coverage_d;
            err_cnt_q  <= err_cnt_d;
            if (fail && !first_fail_vld_q) begin
              first_fail_vld_q <= 1'b1;
              first_fail_vec_q <= bus.vec;
            end
            if (&coverage_d) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_cnt_d == '0);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.err_cnt        = err_cnt_q;
  assign bus.coverage       = coverage_q;
  assign bus.first_fail_vld = first_fail_vld_q;
  assign bus.first_fail_vec = first_fail_vec_q;

`ifdef KATIO_CHK_MISR_EN
  localparam int unsigned PadBits = 8 - WIDTH - 2;

  // Sample packed MSB-first, zero padding on the LSB side
  logic [7:0] misr_din;
  assign misr_din = 8'({bus.vec, bus.or_obs, bus.nor_obs}) << PadBits;

  katio_misr8 u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.start),
    .en    (sample),
    .din   (misr_din),
    .sig   (bus.signature)
  );
`endif

endmodule
